// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Holds the clear-sequencer state encoding and the packed-bus slice helper.
package regfile_pkg;

   localparam int unsigned RF_DATA_W   = 32;
   localparam int unsigned RF_NUM_REGS = 32;

   typedef enum logic {
      RF_IDLE,
      RF_CLEAR
   } rf_state_e;

   // Low bit of port idx inside a bus packed as idx*w +: w.
   function automatic int unsigned rf_lo(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for the hazard unit.
// A set beats a same-cycle clear; flush beats everything.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_REGS = RF_NUM_REGS,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                set_en_i,
   input  logic [ADDR_W-1:0]   set_addr_i,
   input  logic [NUM_REGS-1:0] clr_mask_i,
   input  logic                flush_i,
   output logic [NUM_REGS-1:0] pend_o
);

   logic [NUM_REGS-1:0] pend_q;
   logic [NUM_REGS-1:0] pend_d;
   logic [NUM_REGS-1:0] set_mask;

   always_comb begin
      set_mask = '0;
      if (set_en_i) begin
         set_mask[set_addr_i] = 1'b1;
      end
      if (flush_i) begin
         pend_d = '0;
      end else begin
         pend_d = (pend_q & ~clr_mask_i) | set_mask;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pend_o = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass, pending
// scoreboard and a one-register-per-cycle bulk-clear sequencer.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = RF_DATA_W,
   parameter int unsigned NUM_REGS = RF_NUM_REGS,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_WR   = 2,
   parameter bit          BYPASS   = 1'b1,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_WR-1:0]        wr_en_i,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
   input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
   input  logic [NUM_RD-1:0]        rd_en_i,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   input  logic                     rsv_en_i,
   input  logic [ADDR_W-1:0]        rsv_addr_i,
   output logic [NUM_REGS-1:0]      pend_o,
   input  logic                     clr_i,
   output logic                     clr_busy_o
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   logic [DATA_W-1:0]        regs_q [NUM_REGS];
   logic [DATA_W-1:0]        regs_d [NUM_REGS];
   logic [NUM_RD*DATA_W-1:0] rd_q;
   logic [NUM_RD*DATA_W-1:0] rd_d;
   rf_state_e                state_q;
   rf_state_e                state_d;
   logic [ADDR_W-1:0]        cnt_q;
   logic [ADDR_W-1:0]        cnt_d;
   logic [NUM_REGS-1:0]      wr_hit;
   logic                     rsv_ok;
   logic                     flush;

   // Ascending port order makes the highest-index writer win a conflict.
   always_comb begin
      regs_d  = regs_q;
      wr_hit  = '0;
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RF_IDLE: begin
            for (int unsigned k = 0; k < NUM_WR; k++) begin
               if (wr_en_i[k] &&
                   !(ZERO_REG && (wr_addr_i[rf_lo(k, ADDR_W) +: ADDR_W] == '0))) begin
                  regs_d[wr_addr_i[rf_lo(k, ADDR_W) +: ADDR_W]] = wr_data_i[rf_lo(k, DATA_W) +: DATA_W];
                  wr_hit[wr_addr_i[rf_lo(k, ADDR_W) +: ADDR_W]] = 1'b1;
               end
            end
            if (clr_i) begin
               state_d = RF_CLEAR;
               cnt_d   = '0;
            end
         end
         RF_CLEAR: begin
            regs_d[cnt_q] = '0;
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = RF_IDLE;
            end
         end
         default: state_d = RF_IDLE;
      endcase
   end

   // Bypass reads the next-state array, which already folds in accepted
   // writes and the register being cleared this cycle.
   always_comb begin
      rd_d = rd_q;
      for (int unsigned j = 0; j < NUM_RD; j++) begin
         if (rd_en_i[j]) begin
            if (BYPASS) begin
               rd_d[rf_lo(j, DATA_W) +: DATA_W] = regs_d[rd_addr_i[rf_lo(j, ADDR_W) +: ADDR_W]];
            end else begin
               rd_d[rf_lo(j, DATA_W) +: DATA_W] = regs_q[rd_addr_i[rf_lo(j, ADDR_W) +: ADDR_W]];
            end
         end
      end
   end

   always_comb begin
      rsv_ok = rsv_en_i && (state_q == RF_IDLE) && !(ZERO_REG && (rsv_addr_i == '0));
      flush  = clr_i && (state_q == RF_IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         regs_q  <= '{default: '0};
         rd_q    <= '0;
         state_q <= RF_IDLE;
         cnt_q   <= '0;
      end else begin
         regs_q  <= regs_d;
         rd_q    <= rd_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_scoreboard (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .set_en_i   (rsv_ok),
      .set_addr_i (rsv_addr_i),
      .clr_mask_i (wr_hit),
      .flush_i    (flush),
      .pend_o     (pend_o)
   );

   assign rd_data_o  = rd_q;
   assign clr_busy_o = (state_q == RF_CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp: a bypassing and a
// non-bypassing instance share stimulus and are checked against an array model.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic        clr;

   logic [63:0] rd_b, rd_n;
   logic [31:0] pend_b, pend_n;
   logic        busy_b, busy_n;

   logic [31:0] m_regs [32];
   logic [31:0] m_rd_b [2];
   logic [31:0] m_rd_n [2];
   logic [31:0] m_pend;
   bit          m_busy;
   int          m_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_byp (
      .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_b), .rsv_en_i(rsv_en),
      .rsv_addr_i(rsv_addr), .pend_o(pend_b), .clr_i(clr), .clr_busy_o(busy_b));

   regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_nobyp (
      .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_n), .rsv_en_i(rsv_en),
      .rsv_addr_i(rsv_addr), .pend_o(pend_n), .clr_i(clr), .clr_busy_o(busy_n));

   task automatic idle_inputs();
      wr_en = '0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
      rsv_en = 1'b0; rsv_addr = '0; clr = 1'b0;
   endtask

   task automatic set_wr(input int k, input logic [4:0] a, input logic [31:0] d);
      wr_en[k] = 1'b1; wr_addr[k*5 +: 5] = a; wr_data[k*32 +: 32] = d;
   endtask

   task automatic set_rd(input int j, input logic [4:0] a);
      rd_en[j] = 1'b1; rd_addr[j*5 +: 5] = a;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_rd_b = '{default: '0}; m_rd_n = '{default: '0};
      m_pend = '0; m_busy = 1'b0; m_cnt = 0;
   endtask

   // Advance the model by one clock using the current inputs, then the DUT.
   task automatic step();
      logic [31:0] nr [32];
      logic [31:0] np;
      logic [4:0]  a;
      nr = m_regs;
      np = m_pend;
      if (m_busy) begin
         nr[m_cnt] = '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            a = wr_addr[k*5 +: 5];
            if (wr_en[k] && a != 0) begin
               nr[a] = wr_data[k*32 +: 32];
               np[a] = 1'b0;
            end
         end
         if (rsv_en && rsv_addr != 0) np[rsv_addr] = 1'b1;
         if (clr) np = '0;
      end
      for (int j = 0; j < 2; j++) begin
         if (rd_en[j]) begin
            a = rd_addr[j*5 +: 5];
            m_rd_b[j] = nr[a];
            m_rd_n[j] = m_regs[a];
         end
      end
      if (m_busy) begin
         if (m_cnt == 31) m_busy = 1'b0;
         m_cnt = (m_cnt + 1) % 32;
      end else if (clr) begin
         m_busy = 1'b1;
         m_cnt  = 0;
      end
      m_regs = nr;
      m_pend = np;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      model_reset();
      #12;
      n_cmp++;
      if (rd_b !== 64'h0 || rd_n !== 64'h0) begin
         n_fail++; $display("FAIL reset_rd: got %h/%h expected 0", rd_b, rd_n);
      end
      n_cmp++;
      if (pend_b !== 32'h0 || busy_b !== 1'b0) begin
         n_fail++; $display("FAIL reset_pend_busy: got pend %h busy %b expected 0/0", pend_b, busy_b);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      set_rd(0, 5); set_rd(1, 31);
      step();
      n_cmp++;
      if (rd_b !== 64'h0) begin
         n_fail++; $display("FAIL reset_read_5_31: got %h expected 0", rd_b);
      end
   endtask

   task automatic test_bypass();
      idle_inputs();
      set_wr(0, 3, 32'hDEADBEEF); set_rd(0, 3);
      step();
      n_cmp++;
      if (rd_b[31:0] !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL bypass_on: got %h expected deadbeef", rd_b[31:0]);
      end
      n_cmp++;
      if (rd_n[31:0] !== 32'h0) begin
         n_fail++; $display("FAIL bypass_off_old: got %h expected 0", rd_n[31:0]);
      end
      idle_inputs(); set_rd(0, 3);
      step();
      n_cmp++;
      if (rd_n[31:0] !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL bypass_off_new: got %h expected deadbeef", rd_n[31:0]);
      end
   endtask

   task automatic test_conflict();
      idle_inputs();
      set_wr(0, 7, 32'h11111111); set_wr(1, 7, 32'h22222222);
      step();
      idle_inputs(); set_wr(0, 0, 32'hFFFFFFFF); set_rd(0, 7);
      step();
      idle_inputs(); set_rd(0, 0); set_rd(1, 7);
      step();
      n_cmp++;
      if (rd_n[63:32] !== 32'h22222222 || rd_b[63:32] !== 32'h22222222) begin
         n_fail++; $display("FAIL conflict_high_port: got %h/%h expected 22222222", rd_b[63:32], rd_n[63:32]);
      end
      n_cmp++;
      if (rd_b[31:0] !== 32'h0 || rd_n[31:0] !== 32'h0) begin
         n_fail++; $display("FAIL zero_reg: got %h/%h expected 0", rd_b[31:0], rd_n[31:0]);
      end
   endtask

   task automatic test_scoreboard();
      idle_inputs(); rsv_en = 1'b1; rsv_addr = 9;
      step();
      n_cmp++;
      if (pend_b[9] !== 1'b1) begin
         n_fail++; $display("FAIL pend_set: got %b expected 1", pend_b[9]);
      end
      idle_inputs(); set_wr(1, 9, 32'h99);
      step();
      n_cmp++;
      if (pend_b[9] !== 1'b0) begin
         n_fail++; $display("FAIL pend_clr: got %b expected 0", pend_b[9]);
      end
      idle_inputs(); rsv_en = 1'b1; rsv_addr = 9; set_wr(0, 9, 32'h98);
      step();
      n_cmp++;
      if (pend_b[9] !== 1'b1) begin
         n_fail++; $display("FAIL pend_set_wins: got %b expected 1", pend_b[9]);
      end
      idle_inputs(); rsv_en = 1'b1; rsv_addr = 0;
      step();
      n_cmp++;
      if (pend_b !== m_pend) begin
         n_fail++; $display("FAIL pend_rsv_zero: got %h expected %h", pend_b, m_pend);
      end
   endtask

   task automatic read_all(input string tag);
      for (int a = 0; a < 32; a += 2) begin
         idle_inputs(); set_rd(0, 5'(a)); set_rd(1, 5'(a + 1));
         step();
         n_cmp++;
         if (rd_b !== {m_rd_b[1], m_rd_b[0]} || rd_b !== 64'h0) begin
            n_fail++; $display("FAIL %s_reg%0d: got %h expected 0", tag, a, rd_b);
         end
      end
   endtask

   task automatic run_clear(input string tag, input int abort_at, output int busy_cycles);
      idle_inputs(); clr = 1'b1;
      step();
      busy_cycles = 0;
      while (busy_b === 1'b1 && busy_cycles < 100) begin
         busy_cycles++;
         idle_inputs();
         if (busy_cycles == 5) begin
            set_wr(0, 4, 32'h44444444); rsv_en = 1'b1; rsv_addr = 4; clr = 1'b1;
         end
         set_rd(1, 5'(busy_cycles));
         if (busy_cycles == abort_at) begin
            rst = 1'b1;
            model_reset();
            #2;
            rst = 1'b0;
            break;
         end
         step();
         n_cmp++;
         if (busy_b !== m_busy || pend_b !== m_pend || rd_b !== {m_rd_b[1], m_rd_b[0]}) begin
            n_fail++;
            $display("FAIL %s_cyc%0d: got busy %b pend %h rd %h expected %b %h %h", tag, busy_cycles,
                     busy_b, pend_b, rd_b, m_busy, m_pend, {m_rd_b[1], m_rd_b[0]});
         end
      end
   endtask

   task automatic test_clear();
      int n;
      idle_inputs();
      for (int a = 1; a < 32; a += 2) begin
         idle_inputs(); set_wr(0, 5'(a), $urandom | 32'h1); set_wr(1, 5'(a + 1), $urandom | 32'h1);
         step();
      end
      run_clear("clear", -1, n);
      n_cmp++;
      if (n !== 32) begin
         n_fail++; $display("FAIL clear_busy_len: got %0d expected 32", n);
      end
      read_all("clear_after");
   endtask

   task automatic test_reset_mid_clear();
      int n;
      for (int a = 1; a < 32; a++) begin
         idle_inputs(); set_wr(1, 5'(a), 32'hA5A50000 | a);
         step();
      end
      run_clear("abort", 10, n);
      n_cmp++;
      if (busy_b !== 1'b0 || pend_b !== 32'h0) begin
         n_fail++; $display("FAIL abort_idle: got busy %b pend %h expected 0/0", busy_b, pend_b);
      end
      @(posedge clk); #1;
      run_clear("reclear", -1, n);
      n_cmp++;
      if (n !== 32) begin
         n_fail++; $display("FAIL reclear_len: got %0d expected 32", n);
      end
      read_all("abort_after");
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         idle_inputs();
         wr_en    = 2'($urandom);
         wr_addr  = 10'($urandom);
         wr_data  = {$urandom, $urandom};
         rd_en    = 2'($urandom);
         rd_addr  = 10'($urandom);
         if ($urandom_range(3) == 0) rd_addr[9:5] = wr_addr[4:0];
         rsv_en   = 1'($urandom);
         rsv_addr = ($urandom_range(3) == 0) ? wr_addr[4:0] : 5'($urandom);
         clr      = ($urandom_range(59) == 0);
         step();
         n_cmp++;
         if (rd_b !== {m_rd_b[1], m_rd_b[0]} || rd_n !== {m_rd_n[1], m_rd_n[0]} ||
             pend_b !== m_pend || pend_n !== m_pend || busy_b !== m_busy || busy_n !== m_busy) begin
            n_fail++;
            $display("FAIL random_cyc%0d: got rd %h/%h pend %h busy %b expected rd %h/%h pend %h busy %b",
                     c, rd_b, rd_n, pend_b, busy_b, {m_rd_b[1], m_rd_b[0]}, {m_rd_n[1], m_rd_n[0]},
                     m_pend, m_busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_conflict();
      test_scoreboard();
      test_clear();
      test_reset_mid_clear();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
